// File: rtl/conv_anchor_pkg.sv
// Shared types for the configurable CNN anchor generator: state encoding, job config and legality check.
package conv_anchor_pkg;

  localparam int DEF_COORD_W = 16;
  localparam int DEF_CH_W    = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] h;
    logic [DEF_COORD_W-1:0] w;
    logic [DEF_COORD_W-1:0] kh;
    logic [DEF_COORD_W-1:0] kw;
    logic [DEF_COORD_W-1:0] sh;
    logic [DEF_COORD_W-1:0] sw;
    logic [DEF_CH_W-1:0]    c;
  } anchor_cfg_t;

  function automatic logic cfg_legal(input anchor_cfg_t cfg);
    return (cfg.sh != '0) && (cfg.sw != '0) && (cfg.c != '0) &&
           (cfg.kh != '0) && (cfg.kw != '0) &&
           (cfg.kh <= cfg.h) && (cfg.kw <= cfg.w);
  endfunction

endpackage

// File: rtl/anchor_axis_counter.sv
// One stride counter along a feature-map axis; wrap_o flags that the current position is the last fitting one.
// The fit test runs two bits wider than the coordinate so positions near full scale cannot alias.
module anchor_axis_counter #(
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic [COORD_W-1:0] stride_i,
  input  logic [COORD_W-1:0] ker_i,
  input  logic [COORD_W-1:0] dim_i,
  output logic [COORD_W-1:0] cur_o,
  output logic               wrap_o
);

  logic [COORD_W-1:0] cur_q, cur_d;
  logic [COORD_W+1:0] next_end;

  assign next_end = {2'b00, cur_q} + {2'b00, stride_i} + {2'b00, ker_i};
  assign wrap_o   = next_end > {2'b00, dim_i};
  assign cur_o    = cur_q;

  always_comb begin
    cur_d = cur_q;
    if (clear_i)     cur_d = '0;
    else if (step_i) cur_d = wrap_o ? '0 : cur_q + stride_i;
  end

  always_ff @(posedge clk) begin
    if (rst) cur_q <= '0;
    else     cur_q <= cur_d;
  end

endmodule

// File: rtl/conv_anchor_gen_cfg.sv
// Per-job configurable anchor generator: streams (row, col, channel) window anchors, col fastest, 1/cycle.
// First anchor one cycle after start; anchor and flags hold while out_ready is low.
module conv_anchor_gen_cfg
  import conv_anchor_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int CH_W    = DEF_CH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] cfg_img_h,
  input  logic [COORD_W-1:0] cfg_img_w,
  input  logic [COORD_W-1:0] cfg_ker_h,
  input  logic [COORD_W-1:0] cfg_ker_w,
  input  logic [COORD_W-1:0] cfg_stride_h,
  input  logic [COORD_W-1:0] cfg_stride_w,
  input  logic [CH_W-1:0]    cfg_channels,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] anchor_h,
  output logic [COORD_W-1:0] anchor_w,
  output logic [CH_W-1:0]    anchor_ch,
  output logic               last_row,
  output logic               last_frame,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [CH_W-1:0] CH_ONE = 1;

  state_t      state_q;
  anchor_cfg_t cfg_q, cfg_in;
  logic [CH_W-1:0] ch_q;
  logic out_valid_q, busy_q, done_q, cfg_err_q;
  logic fire, clr, col_wrap, row_wrap, last_ch;

  assign cfg_in = '{h: cfg_img_h, w: cfg_img_w, kh: cfg_ker_h, kw: cfg_ker_w,
                    sh: cfg_stride_h, sw: cfg_stride_w, c: cfg_channels};

  // An abort in the same cycle as a handshake cancels it: the anchor is not issued.
  assign fire    = (state_q == RUN) && out_valid_q && out_ready && !abort;
  assign clr     = (state_q != RUN) || abort;
  assign last_ch = (ch_q == cfg_q.c - CH_ONE);

  anchor_axis_counter #(.COORD_W(COORD_W)) u_col (
    .clk(clk), .rst(rst), .clear_i(clr), .step_i(fire),
    .stride_i(cfg_q.sw), .ker_i(cfg_q.kw), .dim_i(cfg_q.w),
    .cur_o(anchor_w), .wrap_o(col_wrap)
  );

  anchor_axis_counter #(.COORD_W(COORD_W)) u_row (
    .clk(clk), .rst(rst), .clear_i(clr), .step_i(fire && col_wrap),
    .stride_i(cfg_q.sh), .ker_i(cfg_q.kh), .dim_i(cfg_q.h),
    .cur_o(anchor_h), .wrap_o(row_wrap)
  );

  assign anchor_ch  = ch_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign last_row   = out_valid_q && col_wrap;
  assign last_frame = last_row && row_wrap && last_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_legal(cfg_in)) begin
              cfg_q       <= cfg_in;
              ch_q        <= '0;
              state_q     <= RUN;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ch_q        <= '0;
          end else if (fire) begin
            if (last_frame) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              ch_q        <= '0;
            end else if (col_wrap && row_wrap) begin
              ch_q <= ch_q + CH_ONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_anchor_gen_cfg.sv
// Bench for conv_anchor_gen_cfg: directed and randomized jobs against an index-based anchor list model.
module tb_conv_anchor_gen_cfg;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [15:0] cfg_img_h, cfg_img_w, cfg_ker_h, cfg_ker_w, cfg_stride_h, cfg_stride_w;
  logic [7:0]  cfg_channels;
  logic        out_valid, last_row, last_frame, busy, done, cfg_err;
  logic [15:0] anchor_h, anchor_w;
  logic [7:0]  anchor_ch;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int h; int w; int kh; int kw; int sh; int sw; int c;
  } tcfg_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] w;
    logic [7:0]  ch;
    logic        lr;
    logic        lf;
  } anc_t;

  anc_t exp_q[$];

  conv_anchor_gen_cfg dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_img_h(cfg_img_h), .cfg_img_w(cfg_img_w),
    .cfg_ker_h(cfg_ker_h), .cfg_ker_w(cfg_ker_w),
    .cfg_stride_h(cfg_stride_h), .cfg_stride_w(cfg_stride_w),
    .cfg_channels(cfg_channels),
    .out_valid(out_valid), .out_ready(out_ready),
    .anchor_h(anchor_h), .anchor_w(anchor_w), .anchor_ch(anchor_ch),
    .last_row(last_row), .last_frame(last_frame),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream built from window counts, not from counter stepping.
  function automatic void build(input tcfg_t k);
    longint nr, nc;
    anc_t a;
    exp_q.delete();
    nr = (longint'(k.h) - k.kh) / k.sh + 1;
    nc = (longint'(k.w) - k.kw) / k.sw + 1;
    for (int ch = 0; ch < k.c; ch++)
      for (longint i = 0; i < nr; i++)
        for (longint j = 0; j < nc; j++) begin
          a.h  = 16'(i * k.sh);
          a.w  = 16'(j * k.sw);
          a.ch = 8'(ch);
          a.lr = (j == nc - 1);
          a.lf = (j == nc - 1) && (i == nr - 1) && (ch == k.c - 1);
          exp_q.push_back(a);
        end
  endfunction

  function automatic logic [63:0] obs_anc();
    anc_t a;
    a = '{h: anchor_h, w: anchor_w, ch: anchor_ch, lr: last_row, lf: last_frame};
    return 64'(a);
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({out_valid, anchor_h, anchor_w, anchor_ch, last_row, last_frame, busy, done, cfg_err});
  endfunction

  function automatic logic [63:0] ctl();
    return 64'({cfg_err, out_valid, busy, done});
  endfunction

  task automatic drive_cfg(input tcfg_t k);
    cfg_img_h    = 16'(k.h);
    cfg_img_w    = 16'(k.w);
    cfg_ker_h    = 16'(k.kh);
    cfg_ker_w    = 16'(k.kw);
    cfg_stride_h = 16'(k.sh);
    cfg_stride_w = 16'(k.sw);
    cfg_channels = 8'(k.c);
  endtask

  task automatic scramble_cfg();
    cfg_img_h    = 16'($urandom);
    cfg_img_w    = 16'($urandom);
    cfg_ker_h    = 16'($urandom);
    cfg_ker_w    = 16'($urandom);
    cfg_stride_h = 16'($urandom);
    cfg_stride_w = 16'($urandom);
    cfg_channels = 8'($urandom);
  endtask

  // abort_at / rst_at: accepted-anchor index at which to cancel (-1 = never).
  // start_at: run cycle at which a stray start is pulsed (-1 = never).
  task automatic run_job(input tcfg_t k, input int ready_pct, input int abort_at,
                         input int rst_at, input int start_at, input string tag);
    int idx, cyc;
    logic rdy, stalled;
    logic [63:0] prev;
    build(k);
    @(negedge clk);
    drive_cfg(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " latency"}, 64'({out_valid, busy}), 64'(2'b11));
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (idx < exp_q.size()) begin
      if (cyc > 3000) begin
        chk({tag, " timeout"}, 64'(idx), 64'(exp_q.size()));
        return;
      end
      chk({tag, " anchor"}, obs_anc(), 64'(exp_q[idx]));
      chk({tag, " valid"}, 64'(out_valid), 64'(1));
      if (stalled) chk({tag, " stall_hold"}, obs_anc(), prev);
      if (idx == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        chk({tag, " abort"}, ctl(), 64'(0));
        @(negedge clk);
        chk({tag, " abort_nodone"}, ctl(), 64'(0));
        return;
      end
      if (idx == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tag, " midjob_rst"}, all_out(), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk({tag, " post_rst"}, all_out(), 64'(0));
        return;
      end
      rdy = ($urandom_range(99) < 32'(ready_pct));
      out_ready = rdy;
      scramble_cfg();
      start = (cyc == start_at);
      prev = obs_anc();
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (rdy) begin
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    out_ready = 1'b0;
    chk({tag, " done"}, ctl(), 64'(4'b0001));
    @(negedge clk);
    chk({tag, " idle"}, ctl(), 64'(0));
  endtask

  task automatic bad_cfg(input tcfg_t k, input string tag);
    @(negedge clk);
    drive_cfg(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " err"}, ctl(), 64'(4'b1000));
    @(negedge clk);
    chk({tag, " err_clear"}, ctl(), 64'(0));
    @(negedge clk);
    chk({tag, " stay_idle"}, ctl(), 64'(0));
  endtask

  initial begin
    tcfg_t c1, c2, cb, cx;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    c1 = '{h: 4, w: 4, kh: 3, kw: 3, sh: 1, sw: 1, c: 1};
    c2 = '{h: 5, w: 7, kh: 3, kw: 3, sh: 2, sw: 2, c: 2};
    drive_cfg(c1);
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset", all_out(), 64'(0));

    // Abort while idle must be harmless.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", ctl(), 64'(0));

    run_job(c1, 100, -1, -1, -1, "basic");
    run_job(c2, 100, -1, -1, 2, "strided");
    run_job(c2, 50, -1, -1, -1, "backpressure");

    cb = c2;
    cb.sw = 0;
    bad_cfg(cb, "sw_zero");
    cb = c2;
    cb.kh = 6;
    bad_cfg(cb, "kh_gt_h");

    run_job(c2, 70, 3, -1, -1, "abort");
    run_job(c2, 100, -1, -1, 1, "restart");
    run_job(c1, 100, -1, 1, -1, "rst_mid");

    cx = '{h: 65535, w: 65535, kh: 1, kw: 1, sh: 65535, sw: 65535, c: 1};
    run_job(cx, 100, -1, -1, -1, "extreme");
    chk("extreme_count", 64'(exp_q.size()), 64'(1));

    for (int n = 0; n < 4; n++) begin
      tcfg_t cr;
      cr.h  = int'($urandom_range(9, 1));
      cr.w  = int'($urandom_range(9, 1));
      cr.kh = int'($urandom_range(cr.h, 1));
      cr.kw = int'($urandom_range(cr.w, 1));
      cr.sh = int'($urandom_range(3, 1));
      cr.sw = int'($urandom_range(3, 1));
      cr.c  = int'($urandom_range(3, 1));
      run_job(cr, 60, -1, -1, -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
